// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int FETCH_PC_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, word} entries with flush and a combinational head read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                     CLK,
  input  logic                     Reset_L,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         wdata,
  output T                         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_reg [DEPTH];
  logic [AW-1:0] rdptr_reg;
  logic [AW-1:0] wrptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push && !flush) begin
      mem_reg[wrptr_reg] <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rdptr_reg <= '0;
      wrptr_reg <= '0;
      count_reg <= '0;
    end else if (flush) begin
      rdptr_reg <= '0;
      wrptr_reg <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wrptr_reg <= wrptr_reg + AW'(1);
      if (do_pop)  rdptr_reg <= rdptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_reg[rdptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential prefetcher: one outstanding imem request, results buffered with PCs,
// redirects flush the buffer and retarget fetch (draining any in-flight request).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic [PC_W-1:0] startPC,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirectPC,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     word;
  } entry_t;

  fetch_state_t    state_reg;
  logic [PC_W-1:0] fetch_pc_reg;
  logic [PC_W-1:0] req_addr_reg;
  logic [PC_W-1:0] req_addr_inc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            room;
  entry_t          wr_entry;
  entry_t          head;

  assign push         = (state_reg == REQ) & imem_ack & ~redirect;
  assign pop          = ~fifo_empty & inst_ready;
  assign count_next   = count + CW'(push) - CW'(pop);
  assign room         = (count_next < CW'(DEPTH));
  assign req_addr_inc = req_addr_reg + PC_W'(INST_BYTES);
  assign wr_entry     = '{pc: req_addr_reg, word: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata   (wr_entry),
    .rdata   (head),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= startPC;
      req_addr_reg <= '0;
    end else if (redirect) begin
      fetch_pc_reg <= redirectPC;
      case (state_reg)
        IDLE: begin
          req_addr_reg <= redirectPC;
          state_reg    <= REQ;
        end
        // Without an ack the old transaction must still finish, so its address is held.
        REQ: begin
          if (imem_ack) req_addr_reg <= redirectPC;
          else          state_reg    <= DROP;
        end
        default: ;
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          if (room) begin
            req_addr_reg <= fetch_pc_reg;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc_reg <= req_addr_inc;
            if (room) req_addr_reg <= req_addr_inc;
            else      state_reg    <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_addr_reg <= fetch_pc_reg;
            state_reg    <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Requests are only issued with room to spare, so a push never meets a full FIFO.
  assert property (@(posedge CLK) disable iff (!Reset_L) !(push && fifo_full && !pop));

  assign imem_req   = (state_reg != IDLE);
  assign imem_addr  = req_addr_reg;
  assign inst_valid = ~fifo_empty;
  assign inst       = head.word;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model plus directed literal checks.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  logic            CLK = 1'b0;
  logic            Reset_L = 1'b0;
  logic [PC_W-1:0] startPC;
  logic            redirect;
  logic [PC_W-1:0] redirectPC;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            inst_ready;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .startPC    (startPC),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  // Memory model: 0 = zero-wait, 1 = fixed latency, 2 = random ack
  int   ack_mode = 0;
  int   ack_lat  = 0;
  logic rnd_ack  = 1'b0;
  int   wait_cnt;
  logic ack_now;

  always @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)                  wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  always_comb begin
    ack_now = 1'b1;
    case (ack_mode)
      1:       ack_now = (wait_cnt >= ack_lat);
      2:       ack_now = rnd_ack;
      default: ack_now = 1'b1;
    endcase
  end

  assign imem_ack   = imem_req & ack_now;
  assign imem_rdata = mem_word(imem_addr);

  // Reference model: buffer as a queue, fetch described by busy/discard flags.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_ent;
  logic [63:0] m_fetch;
  logic [63:0] m_addr;
  bit          m_busy;
  bit          m_drop;
  bit          m_ack;
  bit          m_pop;
  int          hs_count = 0;
  logic [63:0] last_hs_addr = '0;

  always @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      mq.delete();
      m_fetch = startPC;
      m_addr  = '0;
      m_busy  = 0;
      m_drop  = 0;
    end else begin
      m_ack = m_busy && imem_ack;
      m_pop = (mq.size() > 0) && inst_ready;
      if (imem_req && imem_ack) begin
        hs_count++;
        last_hs_addr = imem_addr;
      end
      if (redirect) begin
        mq.delete();
        m_fetch = redirectPC;
        if (!m_busy) begin
          m_busy = 1;
          m_addr = redirectPC;
        end else if (!m_drop) begin
          if (m_ack) m_addr = redirectPC;
          else       m_drop = 1;
        end
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (!m_busy) begin
          if (mq.size() < DEPTH) begin
            m_busy = 1;
            m_addr = m_fetch;
          end
        end else if (m_drop) begin
          if (m_ack) begin
            m_drop = 0;
            m_addr = m_fetch;
          end
        end else if (m_ack) begin
          m_ent.pc   = m_addr;
          m_ent.word = mem_word(m_addr);
          mq.push_back(m_ent);
          m_fetch = m_addr + 64'd4;
          if (mq.size() < DEPTH) m_addr = m_addr + 64'd4;
          else                   m_busy = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("imem_req", imem_req, m_busy);
    if (m_busy) chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", inst_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("inst", inst, mq[0].word);
      chk("inst_pc", inst_pc, mq[0].pc);
    end
  end

  // Called at a negedge; reset asserts mid-cycle and is released two negedges later.
  task automatic do_reset(input logic [63:0] spc);
    startPC = spc;
    #2 Reset_L = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_L = 1'b1;
  endtask

  int hs0;
  int n;

  initial begin
    redirect   = 1'b0;
    redirectPC = '0;
    inst_ready = 1'b1;
    startPC    = 64'h1000;
    @(negedge CLK);

    // Streaming from 0x1000 with a zero-wait memory
    ack_mode = 0;
    do_reset(64'h1000);
    @(negedge CLK);
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 64'h1000);
    chk("t1_valid0", inst_valid, 1'b0);
    for (int k = 1; k < 6; k++) begin
      @(negedge CLK);
      chk("t1_addr", imem_addr, 64'h1000 + 64'(4 * k));
      chk("t1_pc", inst_pc, 64'h1000 + 64'(4 * (k - 1)));
      chk("t1_word", inst, mem_word(64'h1000 + 64'(4 * (k - 1))));
    end

    // Stalled consumer fills the FIFO, then a single pop allows one fetch
    inst_ready = 1'b0;
    do_reset(64'h1000);
    repeat (10) @(negedge CLK);
    chk("t2_req_idle", imem_req, 1'b0);
    chk("t2_model_count", mq.size(), 4);
    chk("t2_head_pc", inst_pc, 64'h1000);
    hs0 = hs_count;
    inst_ready = 1'b1;
    @(negedge CLK);
    inst_ready = 1'b0;
    repeat (6) @(negedge CLK);
    chk("t2_one_fetch", hs_count - hs0, 1);
    chk("t2_fetch_addr", last_hs_addr, 64'h1010);
    chk("t2_head_after", inst_pc, 64'h1004);
    chk("t2_req_idle2", imem_req, 1'b0);

    // Redirect during the second wait cycle of a slow fetch
    inst_ready = 1'b1;
    ack_mode   = 1;
    ack_lat    = 3;
    do_reset(64'h1000);
    @(negedge CLK);
    chk("t3_addr0", imem_addr, 64'h1000);
    @(negedge CLK);
    redirect   = 1'b1;
    redirectPC = 64'h2000;
    @(negedge CLK);
    redirect = 1'b0;
    chk("t3_hold", imem_addr, 64'h1000);
    chk("t3_valid", inst_valid, 1'b0);
    @(negedge CLK);
    chk("t3_hold2", imem_addr, 64'h1000);
    @(negedge CLK);
    chk("t3_new_addr", imem_addr, 64'h2000);
    chk("t3_new_req", imem_req, 1'b1);
    n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("t3_wait_bound", n < 20, 1'b1);
    chk("t3_first_pc", inst_pc, 64'h2000);
    chk("t3_first_word", inst, mem_word(64'h2000));

    // Redirect coinciding with an ack and a pop
    ack_mode = 0;
    do_reset(64'h1000);
    repeat (4) @(negedge CLK);
    redirect   = 1'b1;
    redirectPC = 64'h3000;
    @(negedge CLK);
    redirect = 1'b0;
    chk("t4_flushed", inst_valid, 1'b0);
    chk("t4_addr", imem_addr, 64'h3000);
    @(negedge CLK);
    chk("t4_valid", inst_valid, 1'b1);
    chk("t4_pc", inst_pc, 64'h3000);

    // Address wrap at the top of the PC space
    redirect   = 1'b1;
    redirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge CLK);
    redirect = 1'b0;
    chk("t5_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge CLK);
    chk("t5_addr_wrap", imem_addr, 64'h0);
    chk("t5_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge CLK);
    chk("t5_pc_wrap", inst_pc, 64'h0);

    // Reset in the middle of a live request with two buffered entries
    inst_ready = 1'b0;
    do_reset(64'h1000);
    repeat (3) @(negedge CLK);
    chk("t6_model_count", mq.size(), 2);
    chk("t6_req_live", imem_req, 1'b1);
    chk("t6_addr_live", imem_addr, 64'h1008);
    do_reset(64'h5000);
    @(negedge CLK);
    chk("t6_restart", imem_addr, 64'h5000);
    chk("t6_restart_req", imem_req, 1'b1);

    // Random ack timing, consumer back-pressure and redirects
    ack_mode = 2;
    inst_ready = 1'b1;
    do_reset({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC);
    hs0 = hs_count;
    for (int i = 0; i < 3000 && errors < 100; i++) begin
      rnd_ack    = ($urandom_range(0, 2) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect   = ($urandom_range(0, 19) == 0);
      redirectPC = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) redirectPC[1:0] = 2'b00;
      @(negedge CLK);
    end
    redirect = 1'b0;
    chk("rand_progress", hs_count - hs0 > 500, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Prefetching instruction fetch stage sitting directly upstream of the processor's decode/control path. Issues sequential 32-bit fetch requests to a variable-latency instruction memory over a req/ack handshake and buffers returned words with their PCs in a small FIFO. The consumer pops `{inst, inst_pc}` with a valid/ready handshake. Redirects from branch resolution flush the FIFO and restart fetching at a new PC.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `PC_W`, 64: PC/address width.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `Reset_L`  in  1  reset Reset_L, asynchronous, active-low.
- `startPC`  in  PC_W  fetch address loaded during reset.
- `redirect`  in  1  flush and restart fetch at `redirectPC`.
- `redirectPC`  in  PC_W  new fetch target.
- `imem_req`  out  1  fetch request, held until acked.
- `imem_addr`  out  PC_W  byte address of request; stable while `imem_req` is high.
- `imem_ack`  in  1  memory response this cycle; meaningful only while `imem_req` is high.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `inst_valid`  out  1  FIFO head valid.
- `inst`  out  32  head instruction.
- `inst_pc`  out  PC_W  head PC.
- `inst_ready`  in  1  consumer accepts head.

## Operation
- Registers: `fetchPC` (next address to request), `reqAddr` (address of in-flight request, drives `imem_addr`), FIFO storage, `rdptr`, `wrptr`, `count`, and state.
- States: IDLE (`imem_req`=0), REQ (request live, result kept), DROP (request live, result discarded after redirect). `imem_req` = (state != IDLE).
- At most one outstanding request.
- Pop = `inst_valid & inst_ready`. Push = ack in REQ without redirect. `count_next = count + push - pop`.
- IDLE: if `count_next < DEPTH`, set `reqAddr <= fetchPC` and go to REQ.
- REQ with ack, no redirect:
  - Push `{reqAddr, imem_rdata}` and set `fetchPC <= reqAddr + 4` (mod 2^PC_W).
  - If `count_next < DEPTH`, set `reqAddr <= reqAddr + 4` and stay in REQ (back-to-back fetches). Otherwise go to IDLE.
- Redirect has priority over everything. It clears `count`, `rdptr`, and `wrptr`, does not pop, and sets `fetchPC <= redirectPC`. Next state depends on the current state:
  - IDLE: set `reqAddr <= redirectPC` and go to REQ.
  - REQ with same-cycle ack: discard the data, set `reqAddr <= redirectPC`, stay in REQ.
  - REQ without ack: go to DROP. `reqAddr` is held because the memory transaction must complete.
  - DROP: stay in DROP; only `fetchPC` updates.
- DROP with ack (no redirect): discard data, set `reqAddr <= fetchPC`, go to REQ.
- Full FIFO: no request is issued, so a push never overflows. Simultaneous push and pop at `count==DEPTH-1` is legal.
- Empty FIFO: `inst_valid`=0. `inst_ready` is ignored.
- `inst`/`inst_pc` are read combinationally from storage at `rdptr`.
- `redirectPC` and `startPC` are used unaligned; there is no alignment check.

## Timing
- Reset values: state IDLE, `fetchPC`=`startPC`, `reqAddr`=0, `count`/pointers=0, storage=0. Outputs: `imem_req`=0, `imem_addr`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0.
- Reset asserted mid-transaction abandons the request immediately. The memory must tolerate `imem_req` dropping.
- First `imem_req` rises at the first rising edge after `Reset_L` deasserts.
- Fetch-to-valid latency: `inst_valid` rises at the edge that samples `imem_ack`.
- With a zero-wait memory (ack same cycle as req), throughput is one instruction per cycle.
- Redirect to new `imem_addr`:
  - From IDLE or REQ-with-ack: the next edge.
  - From REQ without ack: the edge after the old ack arrives.
- `inst_valid` drops at the redirect edge.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE/REQ/DROP), `INST_BYTES`=4, entry typedef `{pc[PC_W-1:0], word[31:0]}`.
- One sub-module, `fetch_fifo`:
  - Parameterised DEPTH, synchronous push/pop/flush.
  - Outputs `count`/empty/full and head data.
- The top level holds the FSM and PC registers.

## Test plan
- Reset with `startPC`=0x1000, zero-wait memory, `inst_ready`=1: `imem_addr` sequence 0x1000, 0x1004, 0x1008…; `inst_pc` follows one cycle behind with matching words.
- `inst_ready`=0, zero-wait memory: exactly 4 pushes occur, then `imem_req`=0 with `count`=4. Pulsing `inst_ready` for 1 cycle produces exactly one new request.
- 3-cycle ack latency, then `redirect` to 0x2000 in the 2nd wait cycle: the ack for the old address is dropped, `imem_addr`=0x2000 on the next request, and no stale entry appears at the output.
- `redirect` to 0x3000 in the same cycle as an ack and a pop: the FIFO is empty next cycle and the next request is 0x3000.
- `fetchPC`=0xFFFF_FFFF_FFFF_FFFC: the next request wraps to 0x0.
- `Reset_L` low while `imem_req`=1 and the FIFO holds 2 entries: outputs are at reset values immediately and fetch restarts at `startPC`.
